// File: rtl/intercal_alu_pkg.sv
// Shared op codes, register map, bus transfer sizes and FSM encoding for the
// INTERCAL ALU engine, plus the 16/32-bit register access helpers.
package intercal_alu_pkg;

  localparam logic [2:0] OP_MINGLE = 3'd0;
  localparam logic [2:0] OP_SELECT = 3'd1;
  localparam logic [2:0] OP_UAND   = 3'd2;
  localparam logic [2:0] OP_UOR    = 3'd3;
  localparam logic [2:0] OP_UXOR   = 3'd4;

  localparam logic [5:0] ADDR_A      = 6'h00;
  localparam logic [5:0] ADDR_A_HI   = 6'h02;
  localparam logic [5:0] ADDR_B      = 6'h04;
  localparam logic [5:0] ADDR_B_HI   = 6'h06;
  localparam logic [5:0] ADDR_CTRL   = 6'h08;
  localparam logic [5:0] ADDR_RES    = 6'h0C;
  localparam logic [5:0] ADDR_RES_HI = 6'h0E;

  typedef enum logic [1:0] {
    SZ_8    = 2'b00,
    SZ_16   = 2'b01,
    SZ_32   = 2'b10,
    SZ_NONE = 2'b11
  } xfer_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A 32-bit register decodes as: base with 16b/32b, or base+2 with 16b only.
  function automatic logic reg_hit(input logic [5:0] addr, input logic [5:0] base,
                                   input xfer_size_e size);
    return ((addr == base) && ((size == SZ_16) || (size == SZ_32))) ||
           ((addr == (base + 6'd2)) && (size == SZ_16));
  endfunction

  function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic upper, input xfer_size_e size);
    if (size == SZ_32) return wdata;
    if (upper) return {wdata[15:0], old_val[15:0]};
    return {old_val[31:16], wdata[15:0]};
  endfunction

  function automatic logic [31:0] read_view(input logic [31:0] val, input logic upper,
                                            input xfer_size_e size);
    if (size == SZ_32) return val;
    if (upper) return {16'b0, val[31:16]};
    return {16'b0, val[15:0]};
  endfunction

endpackage

// File: rtl/intercal_alu_engine_if.sv
// TinyQV peripheral bus bundle: the CPU side is the master, the ALU the slave.
interface intercal_alu_engine_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/intercal_select_step.sv
// One select iteration: packs the A bits flagged by the B slice at the current
// packing pointer and reports how many bits were packed.
module intercal_select_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int PTR_W = 6
) (
  input  logic [STEP-1:0]  a_slice_i,
  input  logic [STEP-1:0]  b_slice_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [WIDTH-1:0] bits_o,
  output logic [PTR_W-1:0] inc_o
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    bits_o = '0;
    inc_o  = '0;
    for (int j = 0; j < STEP; j++) begin
      if (b_slice_i[j]) begin
        bits_o = bits_o | (WIDTH'(a_slice_i[j]) << (ptr_i + inc_o));
        inc_o  = inc_o + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/intercal_alu_engine.sv
// INTERCAL ALU peripheral: operand/control/result registers on the TinyQV bus,
// single-cycle mingle/unary ops and an early-terminating iterative select.
module intercal_alu_engine
  import intercal_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ui_in,
  output logic [7:0]            uo_out,
  intercal_alu_engine_if.slave  bus
);

  localparam int PTR_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  xfer_size_e wr_size, rd_size;
  logic       busy;
  logic       ctrl_wr;
  logic       unused_ui;

  assign wr_size   = xfer_size_e'(bus.data_write_n);
  assign rd_size   = xfer_size_e'(bus.data_read_n);
  assign busy      = (state_q == RUN);
  assign ctrl_wr   = (bus.address == ADDR_CTRL) && (wr_size != SZ_NONE);
  assign uo_out    = '0;
  assign unused_ui = ^ui_in;

  // Select datapath: STEP bits per cycle starting at idx_q.
  logic [STEP-1:0]  a_slice, b_slice;
  logic [WIDTH-1:0] sel_bits;
  logic [PTR_W-1:0] sel_inc, idx_next;
  logic             sel_last;

  assign a_slice  = STEP'(a_q >> idx_q);
  assign b_slice  = STEP'(b_q >> idx_q);
  assign idx_next = idx_q + PTR_W'(STEP);
  // Stop once no B bit at or above the next index is set.
  assign sel_last = (idx_next >= PTR_W'(WIDTH)) || ((b_q >> idx_next) == '0);

  intercal_select_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .PTR_W (PTR_W)
  ) u_step (
    .a_slice_i (a_slice),
    .b_slice_i (b_slice),
    .ptr_i     (ptr_q),
    .bits_o    (sel_bits),
    .inc_o     (sel_inc)
  );

  function automatic logic [WIDTH-1:0] quick_result(input logic [2:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] r;
    rot = {a[0], a[WIDTH-1:1]};
    r   = '0;
    case (op)
      OP_MINGLE: begin
        for (int i = 0; i < WIDTH / 2; i++) begin
          r[2*i+1] = a[i];
          r[2*i]   = b[i];
        end
      end
      OP_UAND: r = a & rot;
      OP_UOR:  r = a | rot;
      OP_UXOR: r = a ^ rot;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    done_d  = done_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE: begin
        if (reg_hit(bus.address, ADDR_A, wr_size))
          a_d = WIDTH'(merge_write(32'(a_q), bus.data_in, bus.address[1], wr_size));
        if (reg_hit(bus.address, ADDR_B, wr_size))
          b_d = WIDTH'(merge_write(32'(b_q), bus.data_in, bus.address[1], wr_size));
        if (ctrl_wr) begin
          op_d    = bus.data_in[2:0];
          done_d  = 1'b0;
          acc_d   = '0;
          idx_d   = '0;
          ptr_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (op_q == OP_SELECT) begin
          acc_d = acc_q | sel_bits;
          ptr_d = ptr_q + sel_inc;
          idx_d = idx_next;
          if (sel_last) begin
            res_d   = acc_q | sel_bits;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          res_d   = quick_result(op_q, a_q, b_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Combinational read port; only a RESULT read during an operation stalls.
  logic        stall;
  logic [31:0] rd_data;

  always_comb begin
    stall   = 1'b0;
    rd_data = '0;
    if (rd_size != SZ_NONE) begin
      if (reg_hit(bus.address, ADDR_A, rd_size)) begin
        rd_data = read_view(32'(a_q), bus.address[1], rd_size);
      end else if (reg_hit(bus.address, ADDR_B, rd_size)) begin
        rd_data = read_view(32'(b_q), bus.address[1], rd_size);
      end else if (bus.address == ADDR_CTRL) begin
        rd_data = {22'b0, done_q, busy, 5'b0, op_q};
      end else if (reg_hit(bus.address, ADDR_RES, rd_size)) begin
        if (busy) stall = 1'b1;
        else      rd_data = read_view(32'(res_q), bus.address[1], rd_size);
      end
    end
  end

  assign bus.data_out   = rd_data;
  assign bus.data_ready = (rd_size != SZ_NONE) && !stall;

endmodule

// File: tb/tb_intercal_alu_engine.sv
// Drives three engine configurations (32/1, 32/4, 16/1) with identical bus
// traffic and compares each against a bit-level reference model.
module tb_intercal_alu_engine;
  import intercal_alu_pkg::*;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo [ND];
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  wr_n = 2'b11;
  logic [1:0]  rd_n = 2'b11;

  intercal_alu_engine_if bus0 ();
  intercal_alu_engine_if bus1 ();
  intercal_alu_engine_if bus2 ();

  assign bus0.address = address; assign bus0.data_in = data_in;
  assign bus0.data_write_n = wr_n; assign bus0.data_read_n = rd_n;
  assign bus1.address = address; assign bus1.data_in = data_in;
  assign bus1.data_write_n = wr_n; assign bus1.data_read_n = rd_n;
  assign bus2.address = address; assign bus2.data_in = data_in;
  assign bus2.data_write_n = wr_n; assign bus2.data_read_n = rd_n;

  logic [31:0] dout [ND];
  logic        rdy  [ND];
  assign dout[0] = bus0.data_out; assign rdy[0] = bus0.data_ready;
  assign dout[1] = bus1.data_out; assign rdy[1] = bus1.data_ready;
  assign dout[2] = bus2.data_out; assign rdy[2] = bus2.data_ready;

  intercal_alu_engine #(.WIDTH(32), .STEP(1)) u_dut0 (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo[0]), .bus(bus0));
  intercal_alu_engine #(.WIDTH(32), .STEP(4)) u_dut1 (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo[1]), .bus(bus1));
  intercal_alu_engine #(.WIDTH(16), .STEP(1)) u_dut2 (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo[2]), .bus(bus2));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd_d [ND];
  logic        rd_r [ND];
  logic        got [ND];
  int          stalls [ND];
  logic [31:0] val [ND];
  logic [31:0] exp_res [ND];

  function automatic int w_of(input int d);
    return (d == 2) ? 16 : 32;
  endfunction

  function automatic int s_of(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a_in,
                                             input logic [31:0] b_in, input int w);
    logic [31:0] a, b, r, rot;
    int k;
    a = a_in & mask_of(w);
    b = b_in & mask_of(w);
    r = 32'h0;
    rot = ((a >> 1) | (a << (w - 1))) & mask_of(w);
    case (op)
      3'd0: for (int i = 0; i < w / 2; i++) begin
              r[2*i+1] = a[i];
              r[2*i]   = b[i];
            end
      3'd1: begin
              k = 0;
              for (int i = 0; i < w; i++)
                if (b[i]) begin
                  r[k] = a[i];
                  k++;
                end
            end
      3'd2: r = a & rot;
      3'd3: r = a | rot;
      3'd4: r = a ^ rot;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b_in,
                                     input int w, input int s);
    logic [31:0] b;
    int h;
    b = b_in & mask_of(w);
    if (op != 3'd1 || b == 32'h0) return 1;
    h = 0;
    for (int i = 0; i < w; i++) if (b[i]) h = i;
    return (h + s) / s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address = a; data_in = d; wr_n = sz; rd_n = 2'b11;
    tick();
    wr_n = 2'b11;
  endtask

  task automatic read_all(input logic [5:0] a, input logic [1:0] sz);
    address = a; rd_n = sz; wr_n = 2'b11;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      rd_d[d] = dout[d];
      rd_r[d] = rdy[d];
    end
    tick();
    rd_n = 2'b11;
  endtask

  // Holds a 32-bit RESULT read until every instance acknowledges it.
  task automatic collect_result();
    bit all_got;
    for (int d = 0; d < ND; d++) begin
      got[d] = 1'b0; stalls[d] = 0; val[d] = '0;
    end
    address = ADDR_RES; rd_n = SZ_32; wr_n = 2'b11;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      all_got = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (!got[d]) begin
          if (rdy[d]) begin
            got[d] = 1'b1;
            val[d] = dout[d];
          end else begin
            stalls[d]++;
          end
        end
        all_got &= got[d];
      end
      tick();
      if (all_got) break;
    end
    rd_n = 2'b11;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] exp;
    int lat;
    bus_write(ADDR_A, a, SZ_32);
    bus_write(ADDR_B, b, SZ_32);
    bus_write(ADDR_CTRL, {29'b0, op}, SZ_32);
    collect_result();
    for (int d = 0; d < ND; d++) begin
      lat = ref_latency(op, b, w_of(d), s_of(d));
      exp = ref_result(op, a, b, w_of(d));
      vectors++;
      if (stalls[d] !== lat) begin
        miscompares++;
        $display("FAIL %s latency dut%0d: got %0d stall cycles, expected %0d", name, d, stalls[d], lat);
      end
      vectors++;
      if (val[d] !== exp) begin
        miscompares++;
        $display("FAIL %s result dut%0d: got %h, expected %h", name, d, val[d], exp);
      end
      exp_res[d] = exp;
    end
    read_all(ADDR_CTRL, SZ_32);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if ({rd_r[d], rd_d[d]} !== {1'b1, 32'h200 | {29'b0, op}}) begin
        miscompares++;
        $display("FAIL %s ctrl dut%0d: got rdy=%b %h, expected rdy=1 %h", name, d, rd_r[d],
                 rd_d[d], 32'h200 | {29'b0, op});
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] addrs [6];
    addrs = '{ADDR_CTRL, ADDR_A, ADDR_A_HI, ADDR_B, ADDR_RES, ADDR_RES_HI};
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      read_all(addrs[i], (i == 0) ? SZ_32 : SZ_16);
      for (int d = 0; d < ND; d++) begin
        vectors++;
        if ({rd_r[d], rd_d[d]} !== {1'b1, 32'h0}) begin
          miscompares++;
          $display("FAIL reset read @%h dut%0d: got rdy=%b %h, expected rdy=1 0", addrs[i], d,
                   rd_r[d], rd_d[d]);
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (uo[d] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset uo_out dut%0d: got %h, expected 00", d, uo[d]);
      end
      exp_res[d] = 32'h0;
    end
  endtask

  task automatic test_mingle();
    run_op(3'd0, 32'h0000_FFFF, 32'h0, "mingle_ffff");
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, "mingle_mix");
  endtask

  task automatic test_select();
    run_op(3'd1, 32'h1234_5678, 32'h0000_00FF, "select_low_byte");
    run_op(3'd1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, "select_all");
    run_op(3'd1, 32'hDEAD_BEEF, 32'h0, "select_none");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0001, "select_ends");
  endtask

  task automatic test_unary();
    run_op(3'd4, 32'h0000_0001, 32'h0, "uxor_one");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0, "uand_ones");
    run_op(3'd3, 32'h0, 32'h0, "uor_zero");
    run_op(3'd6, 32'h1234_5678, 32'h5678_1234, "reserved_op6");
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [1:0]  sz;
    logic [31:0] e32;
    logic [31:0] e16;
  } rd_vec_t;

  task automatic test_partial();
    rd_vec_t tbl [$];
    logic [31:0] exp;
    bus_write(ADDR_A, 32'h1111_2222, SZ_32);
    bus_write(ADDR_A_HI, 32'h0000_BEEF, SZ_16);
    bus_write(ADDR_A, 32'h0000_0055, SZ_8);
    bus_write(ADDR_A_HI, 32'hFFFF_FFFF, SZ_32);
    bus_write(ADDR_B, 32'hAAAA_5555, SZ_32);
    bus_write(ADDR_B, 32'h0000_CAFE, SZ_16);
    tbl.push_back('{ADDR_A,      SZ_32, 32'hBEEF_2222, 32'h0000_2222});
    tbl.push_back('{ADDR_A_HI,   SZ_16, 32'h0000_BEEF, 32'h0});
    tbl.push_back('{ADDR_A,      SZ_16, 32'h0000_2222, 32'h0000_2222});
    tbl.push_back('{ADDR_B,      SZ_32, 32'hAAAA_CAFE, 32'h0000_CAFE});
    tbl.push_back('{6'h10,       SZ_32, 32'h0,         32'h0});
    tbl.push_back('{6'h3C,       SZ_16, 32'h0,         32'h0});
    tbl.push_back('{ADDR_RES,    SZ_8,  32'h0,         32'h0});
    tbl.push_back('{ADDR_RES_HI, SZ_32, 32'h0,         32'h0});
    tbl.push_back('{ADDR_RES,    SZ_32, exp_res[0],    exp_res[2]});
    tbl.push_back('{ADDR_RES_HI, SZ_16, exp_res[0] >> 16, exp_res[2] >> 16});
    foreach (tbl[i]) begin
      read_all(tbl[i].addr, tbl[i].sz);
      for (int d = 0; d < ND; d++) begin
        exp = (w_of(d) == 16) ? tbl[i].e16 : tbl[i].e32;
        vectors++;
        if ({rd_r[d], rd_d[d]} !== {1'b1, exp}) begin
          miscompares++;
          $display("FAIL partial read @%h sz%b dut%0d: got rdy=%b %h, expected rdy=1 %h",
                   tbl[i].addr, tbl[i].sz, d, rd_r[d], rd_d[d], exp);
        end
      end
    end
  endtask

  task automatic test_busy_writes();
    logic [31:0] exp;
    bus_write(ADDR_A, 32'hDEAD_BEEF, SZ_32);
    bus_write(ADDR_B, 32'hFFFF_FFFF, SZ_32);
    bus_write(ADDR_CTRL, 32'h1, SZ_32);
    bus_write(ADDR_A, 32'h1, SZ_32);
    bus_write(ADDR_CTRL, 32'h0, SZ_32);
    bus_write(ADDR_B, 32'h0, SZ_16);
    read_all(ADDR_CTRL, SZ_32);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if ({rd_r[d], rd_d[d]} !== {1'b1, 32'h101}) begin
        miscompares++;
        $display("FAIL busy ctrl dut%0d: got rdy=%b %h, expected rdy=1 00000101", d, rd_r[d], rd_d[d]);
      end
    end
    collect_result();
    for (int d = 0; d < ND; d++) begin
      exp = ref_result(3'd1, 32'hDEAD_BEEF, 32'hFFFF_FFFF, w_of(d));
      vectors++;
      if ({got[d], val[d]} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL busy result dut%0d: got ready=%b %h, expected ready=1 %h", d, got[d], val[d], exp);
      end
      exp_res[d] = exp;
    end
    read_all(ADDR_CTRL, SZ_32);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (rd_d[d] !== 32'h201) begin
        miscompares++;
        $display("FAIL busy no_restart dut%0d: got %h, expected 00000201", d, rd_d[d]);
      end
    end
    read_all(ADDR_A, SZ_32);
    for (int d = 0; d < ND; d++) begin
      vectors++;
      if (rd_d[d] !== (32'hDEAD_BEEF & mask_of(w_of(d)))) begin
        miscompares++;
        $display("FAIL busy a_kept dut%0d: got %h, expected %h", d, rd_d[d],
                 32'hDEAD_BEEF & mask_of(w_of(d)));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, "random");
  endtask

  task automatic test_reset_mid();
    logic [5:0] addrs [4];
    addrs = '{ADDR_CTRL, ADDR_RES, ADDR_A, ADDR_B};
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0, "pre_reset_uand");
    bus_write(ADDR_A, 32'hDEAD_BEEF, SZ_32);
    bus_write(ADDR_B, 32'hFFFF_FFFF, SZ_32);
    bus_write(ADDR_CTRL, 32'h1, SZ_32);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_all(addrs[i], SZ_32);
      for (int d = 0; d < ND; d++) begin
        vectors++;
        if ({rd_r[d], rd_d[d]} !== {1'b1, 32'h0}) begin
          miscompares++;
          $display("FAIL reset_mid read @%h dut%0d: got rdy=%b %h, expected rdy=1 0", addrs[i], d,
                   rd_r[d], rd_d[d]);
        end
      end
    end
    run_op(3'd0, 32'h0000_FFFF, 32'h0, "post_reset_mingle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mingle();
    test_select();
    test_unary();
    test_partial();
    test_busy_writes();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
